// File: rtl/d_src_unit.sv
`default_nettype none
// ============================================================================
//  Module      : d_src_unit
//  Description : Decode-stage pipeline register with source-register decode
//                and an optional per-register pending-write scoreboard.
//
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    f_valid/f_icode/f_rA/f_rB   fetch-stage instruction fields
//    D_stall, D_bubble     hold / insert nop into the D register
//                          (stall wins when both are asserted)
//    sb_set, sb_set_dst    record one pending write to a register
//    sb_clr, sb_clr_dst    retire one pending write to a register
//    D_icode/D_rA/D_rB/D_valid   registered decode-stage fields
//    d_srcA, d_srcB        decoded source register IDs (combinational)
//    d_hazard              a decoded source has a pending write
//    sb_err                sticky scoreboard overflow/underflow flag
//
//  Configuration
//    DSRC_SCOREBOARD_EN    when defined, builds the pending-write counters,
//                          d_hazard and sb_err; otherwise both outputs are
//                          tied to 0 and the sb_* inputs are ignored.
//
//  Revision    : 1.0  initial release
// ============================================================================
module d_src_unit #(
    parameter int REG_W = 4,
    parameter int RNONE = 15,
    parameter int RSP   = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [3:0]       f_icode,
    input  logic [REG_W-1:0] f_rA,
    input  logic [REG_W-1:0] f_rB,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             sb_set,
    input  logic [REG_W-1:0] sb_set_dst,
    input  logic             sb_clr,
    input  logic [REG_W-1:0] sb_clr_dst,
    output logic [3:0]       D_icode,
    output logic [REG_W-1:0] D_rA,
    output logic [REG_W-1:0] D_rB,
    output logic             D_valid,
    output logic [REG_W-1:0] d_srcA,
    output logic [REG_W-1:0] d_srcB,
    output logic             d_hazard,
    output logic             sb_err
);

    localparam logic [REG_W-1:0] c_rnone    = RNONE[REG_W-1:0];
    localparam logic [REG_W-1:0] c_rsp      = RSP[REG_W-1:0];
    localparam logic [3:0]       c_icode_nop = 4'h1;

    // ------------------------------------------------------------------
    // D pipeline register
    // ------------------------------------------------------------------
    logic [3:0]       d_icode_q, d_icode_d;
    logic [REG_W-1:0] d_ra_q, d_ra_d;
    logic [REG_W-1:0] d_rb_q, d_rb_d;
    logic             d_valid_q, d_valid_d;

    always_comb begin
        d_icode_d = d_icode_q;
        d_ra_d    = d_ra_q;
        d_rb_d    = d_rb_q;
        d_valid_d = d_valid_q;
        // Stall has priority over bubble: a stalled stage must not lose
        // the instruction it is holding.
        if (!D_stall) begin
            if (D_bubble) begin
                d_icode_d = c_icode_nop;
                d_ra_d    = c_rnone;
                d_rb_d    = c_rnone;
                d_valid_d = 1'b0;
            end else begin
                d_icode_d = f_icode;
                d_ra_d    = f_rA;
                d_rb_d    = f_rB;
                d_valid_d = f_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_icode_q <= c_icode_nop;
            d_ra_q    <= c_rnone;
            d_rb_q    <= c_rnone;
            d_valid_q <= 1'b0;
        end else begin
            d_icode_q <= d_icode_d;
            d_ra_q    <= d_ra_d;
            d_rb_q    <= d_rb_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign D_icode = d_icode_q;
    assign D_rA    = d_ra_q;
    assign D_rB    = d_rb_q;
    assign D_valid = d_valid_q;

    // ------------------------------------------------------------------
    // Source decode
    // ------------------------------------------------------------------
    logic [REG_W-1:0] w_src_a;
    logic [REG_W-1:0] w_src_b;

    always_comb begin
        w_src_a = c_rnone;
        case (d_icode_q)
            4'h2, 4'h4, 4'h6, 4'hA: w_src_a = d_ra_q;
            4'h9, 4'hB:             w_src_a = c_rsp;
            default:                w_src_a = c_rnone;
        endcase
    end

    always_comb begin
        w_src_b = c_rnone;
        case (d_icode_q)
            4'h4, 4'h5, 4'h6:       w_src_b = d_rb_q;
            4'h8, 4'h9, 4'hA, 4'hB: w_src_b = c_rsp;
            default:                w_src_b = c_rnone;
        endcase
    end

    assign d_srcA = w_src_a;
    assign d_srcB = w_src_b;

`ifdef DSRC_SCOREBOARD_EN
    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    localparam int               c_nreg    = 1 << REG_W;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q [c_nreg];
    logic [CNT_W-1:0]  cnt_d [c_nreg];
    logic              err_q, err_d;
    logic [c_nreg-1:0] w_set_vec;
    logic [c_nreg-1:0] w_clr_vec;
    logic              w_hz_a, w_hz_b;

    // One-hot requests; the RNONE slot is never addressed, so its counter
    // stays at its reset value of zero.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (sb_set && (sb_set_dst != c_rnone)) w_set_vec[sb_set_dst] = 1'b1;
        if (sb_clr && (sb_clr_dst != c_rnone)) w_clr_vec[sb_clr_dst] = 1'b1;
    end

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < c_nreg; i++) begin
            cnt_d[i] = cnt_q[i];
            // A set and clear to the same register cancel out.
            if (w_set_vec[i] && !w_clr_vec[i]) begin
                if (cnt_q[i] == c_cnt_max) err_d = 1'b1;
                else                       cnt_d[i] = cnt_q[i] + c_cnt_one;
            end else if (w_clr_vec[i] && !w_set_vec[i]) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_nreg; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < c_nreg; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end

    // Hazard looks only at registered counts: a set/clear in flight this
    // cycle is not visible until the next edge.
    assign w_hz_a   = (w_src_a != c_rnone) && (cnt_q[w_src_a] != '0);
    assign w_hz_b   = (w_src_b != c_rnone) && (cnt_q[w_src_b] != '0);
    assign d_hazard = d_valid_q && (w_hz_a || w_hz_b);
    assign sb_err   = err_q;
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{sb_set, sb_set_dst, sb_clr, sb_clr_dst};
    assign d_hazard    = 1'b0;
    assign sb_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_src_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_src_unit
//  Description : Directed self-checking bench for d_src_unit (default params)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_d_src_unit;

`ifdef DSRC_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       f_valid;
    logic [3:0] f_icode;
    logic [3:0] f_rA, f_rB;
    logic       D_stall, D_bubble;
    logic       sb_set, sb_clr;
    logic [3:0] sb_set_dst, sb_clr_dst;
    logic [3:0] D_icode, D_rA, D_rB;
    logic       D_valid;
    logic [3:0] d_srcA, d_srcB;
    logic       d_hazard, sb_err;

    int checks = 0;
    int errors = 0;

    d_src_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_valid    (f_valid),
        .f_icode    (f_icode),
        .f_rA       (f_rA),
        .f_rB       (f_rB),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .sb_set     (sb_set),
        .sb_set_dst (sb_set_dst),
        .sb_clr     (sb_clr),
        .sb_clr_dst (sb_clr_dst),
        .D_icode    (D_icode),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valid    (D_valid),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .d_hazard   (d_hazard),
        .sb_err     (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        f_icode = ic; f_rA = ra; f_rB = rb; f_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; f_valid = 1'b0; f_icode = 4'h0; f_rA = 4'h0; f_rB = 4'h0;
        D_stall = 1'b0; D_bubble = 1'b0;
        sb_set = 1'b0; sb_clr = 1'b0; sb_set_dst = 4'h0; sb_clr_dst = 4'h0;
        #2 rst_n = 1'b0;
        #1;   // before any clock edge
        checks++; if (D_icode !== 4'h1) begin errors++; $display("FAIL rst_icode: got %0h expected 1", D_icode); end
        checks++; if (D_rA !== 4'hF) begin errors++; $display("FAIL rst_rA: got %0h expected f", D_rA); end
        checks++; if (D_rB !== 4'hF) begin errors++; $display("FAIL rst_rB: got %0h expected f", D_rB); end
        checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", D_valid); end
        checks++; if (d_srcA !== 4'hF || d_srcB !== 4'hF) begin errors++; $display("FAIL rst_src: got %0h/%0h expected f/f", d_srcA, d_srcB); end
        checks++; if (d_hazard !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb: got hz=%0b err=%0b expected 0/0", d_hazard, sb_err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        load(4'h6, 4'h2, 4'h3);
        cyc();
        checks++; if (D_icode !== 4'h6 || D_valid !== 1'b1) begin errors++; $display("FAIL load_icode: got %0h/%0b expected 6/1", D_icode, D_valid); end
        checks++; if (d_srcA !== 4'h2) begin errors++; $display("FAIL load_srcA: got %0h expected 2", d_srcA); end
        checks++; if (d_srcB !== 4'h3) begin errors++; $display("FAIL load_srcB: got %0h expected 3", d_srcB); end
        checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL load_hazard: got %0b expected 0", d_hazard); end
    endtask

    task automatic test_decode_table();
        logic [3:0] exp_a [16];
        logic [3:0] exp_b [16];
        exp_a = '{4'hF, 4'hF, 4'h2, 4'hF, 4'h2, 4'hF, 4'h2, 4'hF,
                  4'hF, 4'h4, 4'h2, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_b = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h3, 4'h3, 4'h3, 4'hF,
                  4'h4, 4'h4, 4'h4, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int ic = 0; ic < 16; ic++) begin
            load(4'(ic), 4'h2, 4'h3);
            cyc();
            checks++;
            if (d_srcA !== exp_a[ic] || d_srcB !== exp_b[ic] || D_icode !== 4'(ic)) begin
                errors++;
                $display("FAIL decode_icode_%0h: got icode=%0h srcA=%0h srcB=%0h expected %0h/%0h/%0h",
                         ic, D_icode, d_srcA, d_srcB, ic, exp_a[ic], exp_b[ic]);
            end
        end
    endtask

    task automatic test_stall_bubble();
        load(4'hB, 4'h5, 4'h7);
        cyc();
        checks++; if (D_icode !== 4'hB || d_srcA !== 4'h4 || d_srcB !== 4'h4) begin errors++; $display("FAIL popl_load: got %0h %0h %0h expected b 4 4", D_icode, d_srcA, d_srcB); end
        D_stall = 1'b1; load(4'h6, 4'h2, 4'h3);
        cyc();
        checks++; if (D_icode !== 4'hB || D_rA !== 4'h5 || d_srcA !== 4'h4 || d_srcB !== 4'h4) begin errors++; $display("FAIL stall_hold: got %0h rA=%0h %0h %0h expected b 5 4 4", D_icode, D_rA, d_srcA, d_srcB); end
        D_bubble = 1'b1;
        cyc();
        checks++; if (D_icode !== 4'hB || D_valid !== 1'b1) begin errors++; $display("FAIL stall_prio: got %0h/%0b expected b/1", D_icode, D_valid); end
        D_stall = 1'b0;
        cyc();
        checks++; if (D_icode !== 4'h1 || d_srcA !== 4'hF || d_srcB !== 4'hF || D_valid !== 1'b0 || D_rA !== 4'hF)
            begin errors++; $display("FAIL bubble: got %0h %0h %0h v=%0b rA=%0h expected 1 f f 0 f", D_icode, d_srcA, d_srcB, D_valid, D_rA); end
        D_bubble = 1'b0;
    endtask

    task automatic test_hazard();
        sb_set = 1'b1; sb_set_dst = 4'h7; load(4'h4, 4'h7, 4'h1);
        cyc();
        sb_set = 1'b0;
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL hazard_set: got %0b expected %0b", d_hazard, SB); end
        D_stall = 1'b1; sb_clr = 1'b1; sb_clr_dst = 4'h7;
        #1;
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL hazard_no_bypass: got %0b expected %0b", d_hazard, SB); end
        cyc();
        sb_clr = 1'b0; D_stall = 1'b0;
        checks++; if (d_hazard !== 1'b0 || D_icode !== 4'h4) begin errors++; $display("FAIL hazard_clr_stalled: got hz=%0b icode=%0h expected 0/4", d_hazard, D_icode); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL hazard_err: got %0b expected 0", sb_err); end
    endtask

    task automatic test_diff_regs();
        sb_set = 1'b1; sb_set_dst = 4'h6; load(4'h6, 4'h5, 4'h6);
        cyc();
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL diff_set6: got %0b expected %0b", d_hazard, SB); end
        sb_set_dst = 4'h5; sb_clr = 1'b1; sb_clr_dst = 4'h6;
        cyc();
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL diff_set5_clr6: got %0b expected %0b", d_hazard, SB); end
        sb_set = 1'b0; sb_clr_dst = 4'h5;
        cyc();
        sb_clr = 1'b0;
        checks++; if (d_hazard !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL diff_clr5: got hz=%0b err=%0b expected 0/0", d_hazard, sb_err); end
    endtask

    task automatic test_same_reg();
        load(4'h2, 4'h3, 4'h0);
        sb_set = 1'b1; sb_set_dst = 4'h3;
        cyc();
        sb_clr = 1'b1; sb_clr_dst = 4'h3;
        cyc();
        checks++; if (d_hazard !== SB || sb_err !== 1'b0) begin errors++; $display("FAIL same_setclr: got hz=%0b err=%0b expected %0b/0", d_hazard, sb_err, SB); end
        sb_set = 1'b0;
        cyc();
        sb_clr = 1'b0;
        checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL same_count_one: got %0b expected 0", d_hazard); end
        sb_set = 1'b1;
        repeat (3) cyc();
        checks++; if (sb_err !== 1'b0 || d_hazard !== SB) begin errors++; $display("FAIL sat_three: got err=%0b hz=%0b expected 0/%0b", sb_err, d_hazard, SB); end
        cyc();
        sb_set = 1'b0;
        checks++; if (sb_err !== SB) begin errors++; $display("FAIL sat_err: got %0b expected %0b", sb_err, SB); end
        sb_clr = 1'b1;
        repeat (2) cyc();
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL sat_cnt_one: got %0b expected %0b", d_hazard, SB); end
        cyc();
        sb_clr = 1'b0;
        checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL sat_cnt_zero: got %0b expected 0", d_hazard); end
        cyc();
        checks++; if (sb_err !== SB) begin errors++; $display("FAIL sat_err_sticky: got %0b expected %0b", sb_err, SB); end
    endtask

    task automatic test_async_reset();
        sb_set = 1'b1; sb_set_dst = 4'h2; load(4'h2, 4'h2, 4'h0);
        cyc();
        sb_set = 1'b0;
        checks++; if (d_hazard !== SB) begin errors++; $display("FAIL areset_pre: got %0b expected %0b", d_hazard, SB); end
        D_stall = 1'b1;
        #3 rst_n = 1'b0;
        #1;   // still before the next edge
        checks++; if (D_icode !== 4'h1 || D_rA !== 4'hF || D_rB !== 4'hF || D_valid !== 1'b0)
            begin errors++; $display("FAIL areset_dreg: got %0h %0h %0h %0b expected 1 f f 0", D_icode, D_rA, D_rB, D_valid); end
        checks++; if (d_srcA !== 4'hF || d_srcB !== 4'hF || d_hazard !== 1'b0 || sb_err !== 1'b0)
            begin errors++; $display("FAIL areset_out: got %0h %0h hz=%0b err=%0b expected f f 0 0", d_srcA, d_srcB, d_hazard, sb_err); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; D_stall = 1'b0;
        cyc();
        checks++; if (D_icode !== 4'h2 || d_srcA !== 4'h2 || d_hazard !== 1'b0) begin errors++; $display("FAIL areset_first_load: got %0h %0h hz=%0b expected 2 2 0", D_icode, d_srcA, d_hazard); end
    endtask

    task automatic test_rnone_underflow();
        sb_set = 1'b1; sb_set_dst = 4'hF; load(4'h6, 4'hF, 4'hF);
        cyc();
        sb_set = 1'b0;
        checks++; if (d_hazard !== 1'b0 || sb_err !== 1'b0 || d_srcA !== 4'hF) begin errors++; $display("FAIL rnone_set: got hz=%0b err=%0b srcA=%0h expected 0 0 f", d_hazard, sb_err, d_srcA); end
        sb_clr = 1'b1; sb_clr_dst = 4'h9;
        cyc();
        sb_clr = 1'b0;
        checks++; if (sb_err !== SB) begin errors++; $display("FAIL underflow_err: got %0b expected %0b", sb_err, SB); end
        load(4'h2, 4'h9, 4'h0);
        repeat (2) cyc();
        checks++; if (sb_err !== SB || d_hazard !== 1'b0) begin errors++; $display("FAIL underflow_sticky: got err=%0b hz=%0b expected %0b/0", sb_err, d_hazard, SB); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_decode_table();
        test_stall_bubble();
        test_hazard();
        test_diff_regs();
        test_same_reg();
        test_async_reset();
        test_rnone_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
